// File: rtl/sound_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sound_arbiter
// Purpose  : Shares the single audio tone generator between game-event
//            sound requests. Request pulses are latched, arbitrated by fixed
//            priority (win > death > level-up > hop) and played for a
//            per-sound number of frame ticks. Everything is flushed when the
//            game returns to the menu.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i            system clock
//   reset_i          synchronous reset, active low
//   tick_i           one-cycle frame tick pulse
//   state_i          game state: 0 MENU, 1 PLAYING, 2 DEAD, 3 WIN
//   req_i            request pulses: [0] hop, [1] level-up, [2] death, [3] win
//   mute_i           forces sound_select_o to silence; scheduling continues
//   sound_select_o   0 silence, 1 hop, 2 level-up, 3 death, 4 win
//   busy_o           high while a sound is scheduled (ignores mute)
//   grant_o          one-cycle one-hot pulse of the sound just (re)started
// ============================================================================
module sound_arbiter #(
    parameter int unsigned HOP_TICKS   = 6,
    parameter int unsigned LEVEL_TICKS = 30,
    parameter int unsigned DEATH_TICKS = 45,
    parameter int unsigned WIN_TICKS   = 90
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic [1:0] state_i,
    input  logic [3:0] req_i,
    input  logic       mute_i,
    output logic [2:0] sound_select_o,
    output logic       busy_o,
    output logic [3:0] grant_o
);

    localparam logic [1:0] GAME_MENU = 2'd0;

    localparam logic [7:0] HOP_LEN   = HOP_TICKS[7:0];
    localparam logic [7:0] LEVEL_LEN = LEVEL_TICKS[7:0];
    localparam logic [7:0] DEATH_LEN = DEATH_TICKS[7:0];
    localparam logic [7:0] WIN_LEN   = WIN_TICKS[7:0];

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [3:0] pend_q, pend_d;
    logic [2:0] cur_q, cur_d;     // sound code of the playing sound, 0 = none
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;

    // Index of the highest-priority set bit (caller guarantees v != 0).
    function automatic logic [1:0] f_top(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [7:0] f_len(input logic [1:0] idx);
        case (idx)
            2'd0:    return HOP_LEN;
            2'd1:    return LEVEL_LEN;
            2'd2:    return DEATH_LEN;
            default: return WIN_LEN;
        endcase
    endfunction

    logic [3:0] cand;
    logic [1:0] cur_idx;
    logic [3:0] cur_bit;
    logic [3:0] higher;
    logic [3:0] rem;
    logic       do_start;
    logic [3:0] start_set;
    logic [1:0] win_idx;
    logic [3:0] win_bit;

    always_comb begin
        cand    = pend_q | req_i;
        // cur_idx is only meaningful in PLAY where cur_q is 1..4.
        cur_idx = 2'(cur_q - 3'd1);
        cur_bit = 4'b0001 << cur_idx;
        // Bits strictly above the current sound; for win the shift wraps to 0
        // and the mask correctly becomes empty.
        higher  = cand & ~((cur_bit << 1) - 4'd1);
        rem     = cand & ~cur_bit;
    end

    always_comb begin
        fsm_d     = fsm_q;
        pend_d    = pend_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        grant_d   = 4'b0000;
        do_start  = 1'b0;
        start_set = cand;
        win_idx   = 2'd0;
        win_bit   = 4'b0000;

        if (state_i == GAME_MENU) begin
            // Menu flush wins over any request or tick on the same edge.
            fsm_d  = ST_IDLE;
            pend_d = 4'b0000;
            cur_d  = 3'd0;
            cnt_d  = 8'd0;
        end else if (fsm_q == ST_IDLE) begin
            if (cand != 4'b0000) begin
                do_start = 1'b1;
            end
        end else begin
            if (higher != 4'b0000) begin
                // Preemption: the interrupted sound is dropped, not resumed.
                do_start = 1'b1;
            end else if ((req_i & cur_bit) != 4'b0000) begin
                cnt_d   = f_len(cur_idx);
                grant_d = cur_bit;
                pend_d  = pend_q | (req_i & ~cur_bit);
            end else if (tick_i && (cnt_q == 8'd1)) begin
                if (rem != 4'b0000) begin
                    // Back-to-back start, no silent cycle in between.
                    do_start  = 1'b1;
                    start_set = rem;
                end else begin
                    fsm_d  = ST_IDLE;
                    cur_d  = 3'd0;
                    cnt_d  = 8'd0;
                    pend_d = 4'b0000;
                end
            end else begin
                if (tick_i && (cnt_q > 8'd1)) begin
                    cnt_d = cnt_q - 8'd1;
                end
                pend_d = pend_q | req_i;
            end
        end

        if (do_start) begin
            win_idx = f_top(start_set);
            win_bit = 4'b0001 << win_idx;
            fsm_d   = ST_PLAY;
            cur_d   = {1'b0, win_idx} + 3'd1;
            cnt_d   = f_len(win_idx);
            grant_d = win_bit;
            pend_d  = start_set & ~win_bit;
            // A game-over cue (death/win) drops any lower-priority backlog.
            if (win_idx[1]) begin
                pend_d = pend_d & ~(win_bit - 4'd1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fsm_q   <= ST_IDLE;
            pend_q  <= 4'b0000;
            cur_q   <= 3'd0;
            cnt_q   <= 8'd0;
            grant_q <= 4'b0000;
        end else begin
            fsm_q   <= fsm_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    assign sound_select_o = mute_i ? 3'd0 : cur_q;
    assign busy_o         = (fsm_q == ST_PLAY);
    assign grant_o        = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_arbiter
// Purpose  : Self-checking bench for sound_arbiter. A behavioural model
//            tracks the playing sound, its remaining tick count and the set
//            of waiting requests; DUT outputs are compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_arbiter;

    localparam int HOP_T   = 6;
    localparam int LEVEL_T = 30;
    localparam int DEATH_T = 45;
    localparam int WIN_T   = 90;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] state;
    logic [3:0] req;
    logic       mute;
    logic [2:0] sound_select;
    logic       busy;
    logic [3:0] grant;

    always #5 clk = ~clk;

    sound_arbiter #(
        .HOP_TICKS  (HOP_T),
        .LEVEL_TICKS(LEVEL_T),
        .DEATH_TICKS(DEATH_T),
        .WIN_TICKS  (WIN_T)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .tick_i        (tick),
        .state_i       (state),
        .req_i         (req),
        .mute_i        (mute),
        .sound_select_o(sound_select),
        .busy_o        (busy),
        .grant_o       (grant)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: sound number (0 none, 1..4), ticks still to play,
    // set of waiting requests and the grant expected this cycle.
    int         m_cur  = 0;
    int         m_left = 0;
    logic [3:0] m_pend = 4'b0000;
    logic [3:0] m_grant = 4'b0000;

    task automatic chk_value(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dur(input int w);
        case (w)
            0:       return HOP_T;
            1:       return LEVEL_T;
            2:       return DEATH_T;
            default: return WIN_T;
        endcase
    endfunction

    function automatic int top(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic m_start(input int w, input logic [3:0] set);
        m_cur   = w + 1;
        m_left  = dur(w);
        m_grant = 4'(1 << w);
        m_pend  = set & ~4'(1 << w);
        // death or win: nothing lower may follow, and nothing higher waits
        if (w >= 2) m_pend = 4'b0000;
    endtask

    task automatic model_edge();
        logic [3:0] cand;
        logic [3:0] rest;
        int         c;
        m_grant = 4'b0000;
        if (!reset || state == 2'd0) begin
            m_cur  = 0;
            m_left = 0;
            m_pend = 4'b0000;
        end else begin
            cand = m_pend | req;
            if (m_cur == 0) begin
                if (cand != 4'b0000) m_start(top(cand), cand);
            end else begin
                c = m_cur - 1;
                if (top(cand) > c) begin
                    m_start(top(cand), cand);
                end else if (req[c]) begin
                    m_left  = dur(c);
                    m_grant = 4'(1 << c);
                    m_pend  = m_pend | (req & ~4'(1 << c));
                end else if (tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        rest = cand & ~4'(1 << c);
                        if (rest != 4'b0000) begin
                            m_start(top(rest), rest);
                        end else begin
                            m_cur  = 0;
                            m_pend = 4'b0000;
                        end
                    end else begin
                        m_pend = m_pend | req;
                    end
                end else begin
                    m_pend = m_pend | req;
                end
            end
        end
    endtask

    task automatic step(input logic t, input logic [1:0] st, input logic [3:0] r,
                        input logic m, input logic rs);
        tick  = t;
        state = st;
        req   = r;
        mute  = m;
        reset = rs;
        @(posedge clk);
        model_edge();
        #1;
        chk_value("sound_select", int'(sound_select), mute ? 0 : m_cur);
        chk_value("busy", int'(busy), (m_cur != 0) ? 1 : 0);
        chk_value("grant", int'(grant), int'(m_grant));
    endtask

    // n frame ticks, each followed by two quiet cycles
    task automatic ticks(input int n, input logic m);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 2'd1, 4'b0000, m, 1'b1);
            step(1'b0, 2'd1, 4'b0000, m, 1'b1);
            step(1'b0, 2'd1, 4'b0000, m, 1'b1);
        end
    endtask

    task automatic req_pulse(input logic [3:0] r);
        step(1'b0, 2'd1, r, 1'b0, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
    endtask

    initial begin
        tick  = 1'b0;
        state = 2'd1;
        req   = 4'b0000;
        mute  = 1'b0;
        reset = 1'b0;

        // reset state
        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 4'b0000, 1'b0, 1'b0);

        // reset while win plays with hop waiting
        req_pulse(4'b1000);
        ticks(2, 1'b0);
        req_pulse(4'b0001);
        ticks(1, 1'b0);
        step(1'b0, 2'd1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd1, 4'b0000, 1'b0, 1'b1);

        // plain hop, full duration
        req_pulse(4'b0001);
        ticks(7, 1'b0);

        // level-up preempts hop; hop does not resume
        req_pulse(4'b0001);
        ticks(2, 1'b0);
        req_pulse(4'b0010);
        ticks(32, 1'b0);

        // hop waits behind level-up and starts back-to-back
        req_pulse(4'b0010);
        ticks(3, 1'b0);
        req_pulse(4'b0001);
        ticks(29, 1'b0);
        ticks(8, 1'b0);

        // hop retriggered after 4 ticks
        req_pulse(4'b0001);
        ticks(4, 1'b0);
        req_pulse(4'b0001);
        ticks(7, 1'b0);

        // start on the same edge as a tick
        step(1'b1, 2'd1, 4'b0001, 1'b0, 1'b1);
        ticks(7, 1'b0);

        // death with hop: hop discarded, mute does not stop scheduling
        req_pulse(4'b0101);
        ticks(10, 1'b1);
        ticks(36, 1'b0);
        req_pulse(4'b0101);
        ticks(5, 1'b1);
        step(1'b1, 2'd0, 4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 4'b0000, 1'b0, 1'b1);

        // randomized traffic
        for (int n = 0; n < 5000; n++) begin
            logic [3:0] r;
            logic [1:0] st;
            r = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(24) == 0) r[b] = 1'b1;
            end
            st = ($urandom_range(299) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
            step(($urandom_range(2) == 0) ? 1'b1 : 1'b0, st, r,
                 ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(999) == 0) ? 1'b0 : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
